// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory slave sequencing controller.
// State encoding, default widths and the R/W bit polarity.
package spi_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF = 8;

    // Value of the R/W bit in the command byte that selects a read.
    localparam logic RW_READ = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GET_ADDR   = 4'd1,
        ST_GOT_ADDR   = 4'd2,
        ST_READ_LOAD  = 4'd3,
        ST_READ_SHIFT = 4'd4,
        ST_READ_INC   = 4'd5,
        ST_WRITE_RECV = 4'd6,
        ST_WRITE_DM   = 4'd7,
        ST_DONE       = 4'd8
    } state_e;

    // A transaction is in progress in every state except IDLE and DONE.
    function automatic logic state_is_busy(input state_e st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for the SPI memory controller.
// Counts increment pulses from zero and flags the pulse that reaches the
// terminal value; clear has priority over increment.
module spi_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] terminal_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step on each increment pulse.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Flag the cycle in which the terminal-th pulse arrives, so the FSM can
    // leave the counting state on that same edge.
    assign done_o = inc_i && !clear_i &&
                    (count_q == (terminal_i - {{(CNT_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/spi_mem_fsm.sv
// Sequencing controller for the SPI memory slave.
// Consumes conditioned chip select and single-cycle SCLK edge pulses and
// drives the shift register load, address latch load, data memory write
// and MISO enable strobes. A transaction is an 8-bit command (address then
// R/W bit, MSB first) followed by an 8-bit data phase.
// Optional build macro SPI_MEM_BURST_READ_EN: reads continue with an
// address increment and reload until chip select rises.
module spi_mem_fsm
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs_cond,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_en,
    output logic addr_inc,
    output logic busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] ADDR_TERM = CNT_W'(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_WIDTH);

    state_e           state_q;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             cnt_done_s;
    logic [CNT_W-1:0] cnt_term_s;

    logic addr_we_s;
    logic sr_we_s;
    logic dm_we_s;
    logic miso_en_s;
    logic busy_s;
`ifdef SPI_MEM_BURST_READ_EN
    logic addr_inc_s;
`endif

    // Counter control: only the edge type relevant to the state is counted;
    // every non-counting state (and chip select high) holds the count at 0.
    always_comb begin
        cnt_clr_s  = 1'b1;
        cnt_inc_s  = 1'b0;
        cnt_term_s = DATA_TERM;
        if (cs_cond) begin
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_GET_ADDR: begin
                    cnt_clr_s  = 1'b0;
                    cnt_inc_s  = sclk_pos;
                    cnt_term_s = ADDR_TERM;
                end
                ST_READ_SHIFT: begin
                    cnt_clr_s = 1'b0;
                    cnt_inc_s = sclk_neg;
                end
                ST_WRITE_RECV: begin
                    cnt_clr_s = 1'b0;
                    cnt_inc_s = sclk_pos;
                end
                default: begin
                    cnt_clr_s = 1'b1;
                    cnt_inc_s = 1'b0;
                end
            endcase
        end
    end

    spi_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst_n     (reset_n),
        .clear_i   (cnt_clr_s),
        .inc_i     (cnt_inc_s),
        .terminal_i(cnt_term_s),
        .done_o    (cnt_done_s)
    );

    // Transaction state machine; chip select high aborts to IDLE from anywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else if (cs_cond) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_GET_ADDR;
                end
                ST_GET_ADDR: begin
                    if (cnt_done_s) begin
                        state_q <= ST_GOT_ADDR;
                    end else begin
                        state_q <= ST_GET_ADDR;
                    end
                end
                ST_GOT_ADDR: begin
                    // The last command bit sits in the shift register LSB now.
                    if (rw_bit == RW_READ) begin
                        state_q <= ST_READ_LOAD;
                    end else begin
                        state_q <= ST_WRITE_RECV;
                    end
                end
                ST_READ_LOAD: begin
                    state_q <= ST_READ_SHIFT;
                end
                ST_READ_SHIFT: begin
                    if (cnt_done_s) begin
`ifdef SPI_MEM_BURST_READ_EN
                        state_q <= ST_READ_INC;
`else
                        state_q <= ST_DONE;
`endif
                    end else begin
                        state_q <= ST_READ_SHIFT;
                    end
                end
`ifdef SPI_MEM_BURST_READ_EN
                ST_READ_INC: begin
                    state_q <= ST_READ_LOAD;
                end
`endif
                ST_WRITE_RECV: begin
                    if (cnt_done_s) begin
                        state_q <= ST_WRITE_DM;
                    end else begin
                        state_q <= ST_WRITE_RECV;
                    end
                end
                ST_WRITE_DM: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the strobes from the current state.
    always_comb begin
        addr_we_s  = 1'b0;
        sr_we_s    = 1'b0;
        dm_we_s    = 1'b0;
        miso_en_s  = 1'b0;
`ifdef SPI_MEM_BURST_READ_EN
        addr_inc_s = 1'b0;
`endif
        busy_s     = state_is_busy(state_q);
        case (state_q)
            ST_GOT_ADDR: begin
                addr_we_s = 1'b1;
            end
            ST_READ_LOAD: begin
                sr_we_s = 1'b1;
`ifdef SPI_MEM_BURST_READ_EN
                // Keep MISO driven across the reload gap between burst bytes.
                miso_en_s = 1'b1;
`endif
            end
            ST_READ_SHIFT: begin
                miso_en_s = 1'b1;
            end
`ifdef SPI_MEM_BURST_READ_EN
            ST_READ_INC: begin
                addr_inc_s = 1'b1;
                miso_en_s  = 1'b1;
            end
`endif
            ST_WRITE_DM: begin
                dm_we_s = 1'b1;
            end
            default: begin
                addr_we_s = 1'b0;
            end
        endcase
    end

    // Chip select high gates every strobe, so a cs rise coincident with
    // WRITE_DM never produces a partial write.
    assign addr_we = addr_we_s & ~cs_cond;
    assign sr_we   = sr_we_s   & ~cs_cond;
    assign dm_we   = dm_we_s   & ~cs_cond;
    assign miso_en = miso_en_s & ~cs_cond;
    assign busy    = busy_s    & ~cs_cond;
`ifdef SPI_MEM_BURST_READ_EN
    assign addr_inc = addr_inc_s & ~cs_cond;
`else
    assign addr_inc = 1'b0;
`endif

endmodule
